// File: rtl/instr_fetch.sv
// Instruction fetch / program sequencer: loadable instruction memory, PC update from branch
// controls, and a two-cycle FETCH/EXEC issue loop feeding the control unit.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter logic [4:0]  HALT_OP = 5'd31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              run,
  input  logic              f,
  input  logic [1:0]        bz_bnz_jmp_jmr,
  input  logic              offset_sel,
  input  logic [15:0]       in_offset,
  input  logic              zero,
  output logic [31:0]       op_code,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_valid,
  output logic              halted,
  output logic [15:0]       retired
);

  localparam int unsigned OP_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [OP_W-1:0]    op_code_q, op_code_d;
  logic               exec_valid_q, exec_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [OP_W-1:0]    mem_q [DEPTH];
  logic [OP_W-1:0]    rd_data_c;
  logic               taken_c;
  logic [ADDR_W-1:0]  target_c;
  logic               unused_offset_c;

  // Only the low ADDR_W offset bits can reach the PC.
  assign unused_offset_c = ^in_offset[15:ADDR_W];

  // Host program port; ignored once execution has started.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign rd_data_c = mem_q[pc_q];

  always_comb begin
    taken_c = 1'b1;
    case (bz_bnz_jmp_jmr)
      2'd0:    taken_c = zero;
      2'd1:    taken_c = ~zero;
      default: taken_c = 1'b1;
    endcase
    target_c = offset_sel ? in_offset[ADDR_W-1:0] : ADDR_W'(pc_q + in_offset[ADDR_W-1:0]);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    op_code_d    = op_code_q;
    exec_valid_d = 1'b0;
    halted_d     = halted_q;
    retired_d    = retired_q;
    case (state_q)
      S_IDLE: begin
        op_code_d = '0;
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op_code_d    = rd_data_c;
        exec_valid_d = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        if (op_code_q[31:27] == HALT_OP) begin
          state_d   = S_HALT;
          op_code_d = '0;
          halted_d  = 1'b1;
        end else begin
          if (retired_q != {CNT_W{1'b1}}) begin
            retired_d = retired_q + CNT_W'(1);
          end
          pc_d = (f && taken_c) ? target_c : ADDR_W'(pc_q + ADDR_W'(1));
          if (run) begin
            state_d = S_FETCH;
          end else begin
            state_d   = S_IDLE;
            op_code_d = '0;
          end
        end
      end
      S_HALT: begin
        if (!run) begin
          state_d  = S_IDLE;
          halted_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      op_code_q    <= '0;
      exec_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_code_q    <= op_code_d;
      exec_valid_q <= exec_valid_d;
      halted_q     <= halted_d;
      retired_q    <= retired_d;
    end
  end

  assign op_code    = op_code_q;
  assign pc         = pc_q;
  assign exec_valid = exec_valid_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: halt program, branch arithmetic, reset mid-run,
// stray writes, run drop during FETCH and same-cycle write+run.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              run;
  logic              f;
  logic [1:0]        bz_bnz_jmp_jmr;
  logic              offset_sel;
  logic [15:0]       in_offset;
  logic              zero;
  logic [31:0]       op_code;
  logic [ADDR_W-1:0] pc;
  logic              exec_valid;
  logic              halted;
  logic [15:0]       retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(256), .HALT_OP(5'd31)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .run(run), .f(f), .bz_bnz_jmp_jmr(bz_bnz_jmp_jmr), .offset_sel(offset_sel),
    .in_offset(in_offset), .zero(zero), .op_code(op_code), .pc(pc),
    .exec_valid(exec_valid), .halted(halted), .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] add_op(input int k);
    return {5'd3, 27'(k)};
  endfunction

  task automatic write_mem(input logic [7:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_exec(input string tag);
    int n = 0;
    while (!exec_valid && n < 6) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(exec_valid), 32'd1);
  endtask

  // One instruction from IDLE with the given branch controls, returning to IDLE.
  task automatic exec_one(input string tag, input logic [7:0] exp_pc, input logic fi,
                          input logic [1:0] ty, input logic os, input logic [15:0] off,
                          input logic z, input logic [7:0] exp_next);
    f = fi; bz_bnz_jmp_jmr = ty; offset_sel = os; in_offset = off; zero = z; run = 1'b1;
    wait_exec(tag);
    check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    run = 1'b0;
    tick();
    check_eq({tag, "_next"}, 32'(pc), 32'(exp_next));
    f = 1'b0; zero = 1'b0;
  endtask

  // mem[0..2] add, mem[3] halt, starting at pc 0 in IDLE.
  task automatic run_halt_prog(input string tag);
    run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k % 2 == 0) begin
        check_eq({tag, "_ev"}, 32'(exec_valid), 32'd1);
        check_eq({tag, "_pc"}, 32'(pc), 32'(k / 2 - 1));
        check_eq({tag, "_op"}, op_code, (k == 8) ? {5'd31, 27'd0} : add_op(k / 2 - 1));
      end else begin
        check_eq({tag, "_ev0"}, 32'(exec_valid), 32'd0);
      end
    end
    check_eq({tag, "_halted"}, 32'(halted), 32'd1);
    check_eq({tag, "_halt_op"}, op_code, 32'd0);
    check_eq({tag, "_retired"}, 32'(retired), 32'd3);
    check_eq({tag, "_halt_pc"}, 32'(pc), 32'd3);
    run = 1'b0;
    tick();
    check_eq({tag, "_unhalt"}, 32'(halted), 32'd0);
    check_eq({tag, "_idle_pc"}, 32'(pc), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; run = 1'b0;
    f = 1'b0; bz_bnz_jmp_jmr = 2'd0; offset_sel = 1'b0; in_offset = '0; zero = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_op", op_code, 32'd0);
    check_eq("rst_ev", 32'(exec_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);

    for (int i = 0; i < 256; i++) write_mem(8'(i), add_op(i));
    write_mem(8'd3, {5'd31, 27'd0});
    run_halt_prog("prog");

    // Branch arithmetic
    write_mem(8'd3, add_op(3));
    do_reset();
    exec_one("seq0", 8'h00, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h01);
    exec_one("seq1", 8'h01, 1'b1, 2'd0, 1'b0, 16'h0004, 1'b0, 8'h02);
    exec_one("bz_t", 8'h02, 1'b1, 2'd0, 1'b0, 16'h0004, 1'b1, 8'h06);
    exec_one("jmp", 8'h06, 1'b1, 2'd2, 1'b1, 16'h0002, 1'b0, 8'h02);
    exec_one("bz_nt", 8'h02, 1'b1, 2'd0, 1'b0, 16'h0004, 1'b0, 8'h03);
    exec_one("seq3", 8'h03, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h04);
    exec_one("seq4", 8'h04, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h05);
    exec_one("bnz_t", 8'h05, 1'b1, 2'd1, 1'b0, 16'hFFFE, 1'b0, 8'h03);
    exec_one("seq3b", 8'h03, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h04);
    exec_one("seq4b", 8'h04, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h05);
    exec_one("bnz_nt", 8'h05, 1'b1, 2'd1, 1'b0, 16'hFFFE, 1'b1, 8'h06);
    exec_one("jmr", 8'h06, 1'b1, 2'd3, 1'b1, 16'h0040, 1'b0, 8'h40);
    exec_one("jmp_ff", 8'h40, 1'b1, 2'd2, 1'b1, 16'h00FF, 1'b0, 8'hFF);
    exec_one("wrap", 8'hFF, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h00);
    check_eq("br_retired", 32'(retired), 32'd14);
    check_eq("br_idle_ev", 32'(exec_valid), 32'd0);
    check_eq("br_idle_op", op_code, 32'd0);

    // Stray write while running, then reset mid-EXEC
    write_mem(8'd3, {5'd31, 27'd0});
    do_reset();
    run = 1'b1;
    wait_exec("s4a");
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = 32'hDEADBEEF;
    tick();
    tick();
    check_eq("s4_ev", 32'(exec_valid), 32'd1);
    check_eq("s4_op", op_code, add_op(1));
    rst = 1'b1; prog_we = 1'b0; run = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("s4_rst_pc", 32'(pc), 32'd0);
    check_eq("s4_rst_op", op_code, 32'd0);
    check_eq("s4_rst_ret", 32'(retired), 32'd0);
    check_eq("s4_rst_ev", 32'(exec_valid), 32'd0);
    run_halt_prog("rerun");

    // Run dropped during FETCH at pc 4
    write_mem(8'd3, add_op(3));
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 20 && !(exec_valid && pc == 8'd3); n++) tick();
    check_eq("s5_pc3", 32'(pc), 32'd3);
    tick();
    check_eq("s5_fetch_ev", 32'(exec_valid), 32'd0);
    run = 1'b0;
    tick();
    check_eq("s5_exec_ev", 32'(exec_valid), 32'd1);
    check_eq("s5_exec_pc", 32'(pc), 32'd4);
    tick();
    check_eq("s5_idle_ev", 32'(exec_valid), 32'd0);
    check_eq("s5_idle_pc", 32'(pc), 32'd5);
    tick();
    check_eq("s5_idle_hold", 32'(pc), 32'd5);
    run = 1'b1;
    tick();
    tick();
    check_eq("s5_resume_ev", 32'(exec_valid), 32'd1);
    check_eq("s5_resume_pc", 32'(pc), 32'd5);
    run = 1'b0;
    tick();
    check_eq("s5_after_pc", 32'(pc), 32'd6);

    // Write and run in the same IDLE cycle at the current pc
    prog_we = 1'b1; prog_addr = 8'd6; prog_data = {5'd3, 27'h123}; run = 1'b1;
    tick();
    prog_we = 1'b0;
    tick();
    check_eq("wr_run_ev", 32'(exec_valid), 32'd1);
    check_eq("wr_run_op", op_code, {5'd3, 27'h123});
    run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
